// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_pkg                                                          |
// | Op encodings, sequencer state type and default ALU latencies.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam int LAT_ADDSUB_DEF = 4;
  localparam int LAT_MULDIV_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_LOAD_A = 3'd2,
    ST_LOAD_B = 3'd3,
    ST_WAIT   = 3'd4,
    ST_CAP_LO = 3'd5,
    ST_CAP_HI = 3'd6,
    ST_DONE   = 3'd7
  } seq_state_e;

  // mul/div return two bytes on outbus, add/sub only one
  function automatic logic is_wide_op(input logic [1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_lat_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_lat_cnt                                                      |
// | Loadable down-counter flagging its final count of one.           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module alu_lat_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign last = (r_count == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_op_sequencer                                                 |
// | Drives one serial ALU_2 operation per command, returns result.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int LAT_ADDSUB = LAT_ADDSUB_DEF,
  parameter int LAT_MULDIV = LAT_MULDIV_DEF,
  parameter int CNT_W      = 4
) (
  input  logic        CLk,
  input  logic        RST_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        alu_rst,
  output logic        alu_begin,
  output logic [1:0]  alu_op,
  output logic [7:0]  alu_inbus,
  input  logic [7:0]  alu_outbus,
  output logic        busy
);

  seq_state_e r_state;
  seq_state_e w_next;

  logic [1:0]  r_op;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic        r_cmd_ready;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_data;
  logic        r_alu_rst;
  logic        r_alu_begin;
  logic [1:0]  r_alu_op;
  logic [7:0]  r_alu_inbus;
  logic        r_busy;

  logic        w_accept;
  logic        w_cnt_load;
  logic        w_cnt_dec;
  logic        w_cnt_last;
  logic [CNT_W-1:0] w_cnt_val;

  logic        w_alu_rst;
  logic        w_alu_begin;
  logic [1:0]  w_alu_op;
  logic [7:0]  w_alu_inbus;

  assign w_accept   = cmd_valid && r_cmd_ready;
  assign w_cnt_load = (r_state == ST_LOAD_B);
  assign w_cnt_dec  = (r_state == ST_WAIT);
  assign w_cnt_val  = is_wide_op(r_op) ? CNT_W'(LAT_MULDIV) : CNT_W'(LAT_ADDSUB);

  alu_lat_cnt #(
    .CNT_W (CNT_W)
  ) u_lat_cnt (
    .clk      (CLk),
    .rst_n    (RST_n),
    .load     (w_cnt_load),
    .load_val (w_cnt_val),
    .dec      (w_cnt_dec),
    .last     (w_cnt_last)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = ST_CLR;
      ST_CLR:    w_next = ST_LOAD_A;
      ST_LOAD_A: w_next = ST_LOAD_B;
      ST_LOAD_B: w_next = ST_WAIT;
      ST_WAIT:   if (w_cnt_last) w_next = ST_CAP_LO;
      ST_CAP_LO: w_next = is_wide_op(r_op) ? ST_CAP_HI : ST_DONE;
      ST_CAP_HI: w_next = ST_DONE;
      ST_DONE:   if (rsp_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Pin values are decoded from the next state so they register in step with it
  always_comb begin
    w_alu_rst   = 1'b0;
    w_alu_begin = 1'b0;
    w_alu_op    = 2'd0;
    w_alu_inbus = 8'h00;
    case (w_next)
      ST_CLR: w_alu_rst = 1'b1;
      ST_LOAD_A: begin
        w_alu_begin = 1'b1;
        w_alu_op    = r_op;
        w_alu_inbus = r_a;
      end
      ST_LOAD_B: begin
        w_alu_begin = 1'b1;
        w_alu_op    = r_op;
        w_alu_inbus = r_b;
      end
      ST_WAIT: begin
        w_alu_begin = 1'b1;
        w_alu_op    = r_op;
      end
      ST_CAP_LO, ST_CAP_HI: w_alu_op = r_op;
      default: ;
    endcase
  end

  always_ff @(posedge CLk or negedge RST_n) begin
    if (!RST_n) begin
      r_state     <= ST_IDLE;
      r_op        <= 2'd0;
      r_a         <= 8'h00;
      r_b         <= 8'h00;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 16'h0000;
      r_alu_rst   <= 1'b0;
      r_alu_begin <= 1'b0;
      r_alu_op    <= 2'd0;
      r_alu_inbus <= 8'h00;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cmd_ready <= (w_next == ST_IDLE);
      r_busy      <= (w_next != ST_IDLE);
      r_rsp_valid <= (w_next == ST_DONE);
      r_alu_rst   <= w_alu_rst;
      r_alu_begin <= w_alu_begin;
      r_alu_op    <= w_alu_op;
      r_alu_inbus <= w_alu_inbus;
      if (w_accept) begin
        r_op <= cmd_op;
        r_a  <= cmd_a;
        r_b  <= cmd_b;
      end
      if (r_state == ST_CAP_LO) begin
        r_rsp_data[7:0] <= alu_outbus;
        if (!is_wide_op(r_op)) begin
          r_rsp_data[15:8] <= 8'h00;
        end
      end
      if (r_state == ST_CAP_HI) begin
        r_rsp_data[15:8] <= alu_outbus;
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign alu_rst   = r_alu_rst;
  assign alu_begin = r_alu_begin;
  assign alu_op    = r_alu_op;
  assign alu_inbus = r_alu_inbus;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Host-side initiator for the serial ALU_2 datapath.
- Accepts one command (op, A, B) over a valid/ready handshake.
- Drives the ALU's `RST`/`Begin`/`op`/`inbus` pins in the fixed load sequence, waits the op's latency, then captures `outbus` (1 or 2 bytes).
- Returns a 16-bit result over a valid/ready response handshake. Sits between the control unit and the ALU instance.

Parameters:
- LAT_ADDSUB, 4: WAIT cycles for op 0/1; must be ≥1.
- LAT_MULDIV, 10: WAIT cycles for op 2/3; must be ≥1.
- CNT_W, 4: latency counter width; must hold max(LAT_*).

Ports:
- CLk  in  1  single clock, rising edge.
- RST_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  0=add, 1=sub, 2=mul, 3=div.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_data  out  16  result; high byte is 0 for op 0/1.
- alu_rst  out  1  to ALU `RST` (active high).
- alu_begin  out  1  to ALU `Begin`.
- alu_op  out  2  to ALU `op`.
- alu_inbus  out  8  to ALU `inbus`.
- alu_outbus  in  8  from ALU `outbus`.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, RST_n=0):
  - state=IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0.
  - alu_rst=0, alu_begin=0, alu_op=0, alu_inbus=0, busy=0.
  - Counter=0; latched op/A/B=0.
- All outputs are registered.
- States: IDLE → CLR → LOAD_A → LOAD_B → WAIT → CAP_LO → [CAP_HI] → DONE → IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch op/A/B, go to CLR.
- CLR (1 cycle):
  - alu_rst=1, alu_begin=0, alu_inbus=0.
- LOAD_A (1 cycle):
  - alu_begin=1, alu_op=latched op, alu_inbus=A.
- LOAD_B (1 cycle):
  - alu_begin=1, alu_inbus=B.
  - Load counter with LAT_ADDSUB (op 0/1) or LAT_MULDIV (op 2/3).
- WAIT:
  - alu_begin=1, alu_inbus=0.
  - Counter decrements each cycle; leave when it reaches 1, so exactly LAT cycles are spent in WAIT.
- CAP_LO:
  - alu_begin=0; sample alu_outbus into rsp_data[7:0].
  - op 0/1: rsp_data[15:8]=0, go to DONE.
  - op 2/3: go to CAP_HI.
- CAP_HI:
  - Sample alu_outbus into rsp_data[15:8].
  - mul: product high byte. div: remainder in [15:8], quotient in [7:0].
- DONE:
  - rsp_valid=1; rsp_data held stable.
  - On rsp_ready: rsp_valid=0 on the next edge, go to IDLE.
- alu_op holds the latched op from LOAD_A through CAP_HI.
- alu_op returns to 0 in DONE/IDLE.
- alu_rst is high only in CLR.
- Latency, with acceptance on edge E0:
  - rsp_valid is high after edge E(LAT+4) for op 0/1.
  - rsp_valid is high after edge E(LAT+5) for op 2/3.
- Back-to-back: no zero-bubble turnaround. cmd_ready rises one cycle after the response handshake.
- cmd_valid while busy is ignored. Inputs are not sampled and nothing is queued.
- rsp_ready while rsp_valid=0 has no effect.
- Reset mid-operation:
  - Returns to IDLE immediately and drops any pending result.
  - alu_rst is not asserted by the reset itself; the next command's CLR cleans the ALU.
- Counter never wraps: it is loaded only in LOAD_B and is ≥1 by parameter rule.

Decomposition:
- Shared package `alu_pkg` holds:
  - Op encodings: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3.
  - State enum for this FSM.
  - Default latency constants, reused by the ALU bench.
- One natural sub-module: `alu_lat_cnt`, a loadable down-counter with a `last` flag.
- Everything else stays in the FSM.

Test Plan:
- add: op=0, A=24, B=31, rsp_ready=1.
  - CLR/LOAD_A/LOAD_B pins exact.
  - rsp_data=0x0037 after E(LAT_ADDSUB+4).
- sub: op=1, A=25, B=16 → rsp_data=0x0009; alu_op=1 throughout LOAD_A..CAP_LO.
- mul: op=2, A=20, B=13 → rsp_data=0x0104; two capture cycles; rsp_valid after E(LAT_MULDIV+5).
- Backpressure: hold rsp_ready=0 for 7 cycles.
  - rsp_valid and rsp_data stable; cmd_ready=0.
  - A second cmd_valid pulse is ignored; only the first result is returned.
- Reset mid-WAIT: RST_n low for 1 cycle.
  - All outputs return to reset values asynchronously; no rsp_valid.
  - The next add (5+3) returns 0x0008 with a fresh CLR pulse.
- Back-to-back div then add: op=3 with 50/7 → 0x0107; then op=0 with 1/1 → 0x0002. cmd_ready returns exactly one cycle after each response handshake.
